// File: rtl/synth_pkg.sv
// Shared definitions for the synth event path: default word width and the
// layout of one queued event (release flag in the MSB, note/control word below).
package synth_pkg;

  localparam int unsigned SynthDataW = 16;

  // Layout of one queued event at the default width.
  typedef struct packed {
    logic                  rel;
    logic [SynthDataW-1:0] data;
  } synth_event_t;

  // Entry width for a given word width: one release bit on top of the word.
  function automatic int unsigned synth_entry_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/synth_event_fifo.sv
// Small synchronous FIFO holding queued synth events.
// A push into a full FIFO is only taken when a pop happens at the same edge.
module synth_event_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Storage is reset so the head word reads as zero right after reset.
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Occupancy follows the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers (wrap naturally modulo Depth) and occupancy.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/synth_event_queue.sv
// Turns changes of the raw note/control word into queued events and hands
// them to the bank manager over a valid/ready handshake. A word of zero
// is a release. Events that arrive while the queue is full are dropped and
// flagged by a sticky overflow bit.
module synth_event_queue
  import synth_pkg::*;
#(
  parameter int unsigned DATA_W = SynthDataW,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_release,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int unsigned EntryW = synth_entry_w(DATA_W);

  logic [DATA_W-1:0] r_last;
  logic              overflow_q;
  logic              change, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [EntryW-1:0] push_entry, head_entry;

  // No event is generated in the reset cycle itself.
  assign change     = (i_data != r_last) && !i_reset;
  assign pop        = o_valid && i_ready;
  assign drop       = change && fifo_full && !pop;
  assign push_entry = {(i_data == '0), i_data};

  synth_event_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (i_reset),
    .push_i  (change),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_count)
  );

  assign o_valid    = !fifo_empty;
  assign o_release  = head_entry[EntryW-1];
  assign o_data     = head_entry[DATA_W-1:0];
  assign o_overflow = overflow_q;

  // Track the previous word and latch any dropped event until reset.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_last     <= '0;
      overflow_q <= 1'b0;
    end else begin
      r_last <= i_data;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synth_event_queue.sv
// Bench for synth_event_queue: directed scenarios plus a randomized run,
// all checked against a queue model of the expected events.
module tb_synth_event_queue;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_valid, o_release, o_overflow;
  logic [DW-1:0] o_data;
  logic [2:0]    o_count;

  synth_event_queue #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_release  (o_release),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  // Model state and scoreboard of expected {release, word} entries.
  logic [DW:0]   sb[$];
  logic [DW-1:0] m_last;
  bit            m_ovf;
  int            n_checks = 0;
  int            n_pass = 0;

  // Per-cycle observations (before the edge) and model expectations.
  logic          obs_valid, obs_rel, obs_ovf;
  logic [DW-1:0] obs_data;
  logic [2:0]    obs_count;
  logic          exp_valid, exp_ovf, popped;
  int            exp_count;
  logic [DW:0]   exp_head;

  // Drive one cycle from a negedge, capture outputs, advance model and clock.
  task automatic tick(input logic [DW-1:0] d, input logic rdy);
    i_data  = d;
    i_ready = rdy;
    #1;
    obs_valid = o_valid;
    obs_rel   = o_release;
    obs_data  = o_data;
    obs_count = o_count;
    obs_ovf   = o_overflow;
    exp_valid = (sb.size() != 0);
    exp_count = sb.size();
    exp_ovf   = m_ovf;
    exp_head  = exp_valid ? sb[0] : '0;
    popped    = exp_valid && rdy;
    if (popped) void'(sb.pop_front());
    if (d != m_last) begin
      if (sb.size() < DEPTH) sb.push_back({(d == '0), d});
      else m_ovf = 1'b1;
    end
    m_last = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [DW-1:0] d);
    i_data  = d;
    i_ready = 1'b0;
    i_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    sb.delete();
    m_last = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(16'h1234);
    #1;
    n_checks++;
    if ({o_valid, o_count, o_overflow} !== 5'b0)
      $display("FAIL reset_status: got v=%b c=%0d o=%b want 0/0/0", o_valid, o_count, o_overflow);
    else n_pass++;
    n_checks++;
    if ({o_release, o_data} !== 17'h0)
      $display("FAIL reset_head: got rel=%b data=%h want 0/0000", o_release, o_data);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single_event();
    int          nvalid;
    logic [DW:0] got;
    nvalid = 0;
    got    = 'x;
    do_reset(16'h0);
    repeat (5) begin
      tick(16'h0040, 1'b1);
      if (obs_valid === 1'b1) begin
        nvalid++;
        got = {obs_rel, obs_data};
      end
    end
    n_checks++;
    if (nvalid !== 1) $display("FAIL single_valid_cycles: got %0d want 1", nvalid);
    else n_pass++;
    n_checks++;
    if (got !== 17'h00040) $display("FAIL single_event: got %h want 00040", got);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [DW:0] exp_seq [3];
    exp_seq = '{17'h00001, 17'h00002, 17'h10000};
    do_reset(16'h0);
    tick(16'h0001, 1'b0);
    tick(16'h0002, 1'b0);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);
    n_checks++;
    if (obs_count !== 3'd3) $display("FAIL seq_count: got %0d want 3", obs_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(16'h0000, 1'b1);
      n_checks++;
      if ({obs_valid, obs_rel, obs_data} !== {1'b1, exp_seq[i]})
        $display("FAIL seq_pop%0d: got v=%b %b/%h want 1 %h", i, obs_valid, obs_rel, obs_data,
                 exp_seq[i]);
      else n_pass++;
    end
    tick(16'h0000, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL seq_empty: got valid=%b want 0", obs_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset(16'h0);
    for (int k = 1; k <= 5; k++) tick(DW'(k), 1'b0);
    tick(16'h0005, 1'b0);
    n_checks++;
    if ({obs_count, obs_ovf} !== {3'd4, 1'b1})
      $display("FAIL ovf_status: got c=%0d o=%b want 4/1", obs_count, obs_ovf);
    else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      tick(16'h0005, 1'b1);
      n_checks++;
      if ({obs_valid, obs_data} !== {1'b1, DW'(k)})
        $display("FAIL ovf_pop%0d: got v=%b %h want 1 %h", k, obs_valid, obs_data, DW'(k));
      else n_pass++;
    end
    tick(16'h0005, 1'b1);
    n_checks++;
    if ({obs_valid, obs_ovf} !== 2'b01)
      $display("FAIL ovf_after_drain: got v=%b o=%b want 0/1", obs_valid, obs_ovf);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    do_reset(16'h0);
    for (int k = 1; k <= 4; k++) tick(DW'(k), 1'b0);
    tick(16'h0005, 1'b1);
    n_checks++;
    if ({obs_count, obs_data} !== {3'd4, 16'h0001})
      $display("FAIL full_pp_head: got c=%0d %h want 4 0001", obs_count, obs_data);
    else n_pass++;
    tick(16'h0005, 1'b0);
    n_checks++;
    if ({obs_count, obs_ovf} !== {3'd4, 1'b0})
      $display("FAIL full_pp_status: got c=%0d o=%b want 4/0", obs_count, obs_ovf);
    else n_pass++;
    for (int k = 2; k <= 5; k++) begin
      tick(16'h0005, 1'b1);
      n_checks++;
      if ({obs_valid, obs_data} !== {1'b1, DW'(k)})
        $display("FAIL full_pp_pop%0d: got v=%b %h want 1 %h", k, obs_valid, obs_data, DW'(k));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int          nvalid;
    logic [DW:0] got;
    nvalid = 0;
    got    = 'x;
    do_reset(16'h0);
    tick(16'h0001, 1'b0);
    tick(16'h0002, 1'b0);
    tick(16'h0003, 1'b0);
    tick(16'h0003, 1'b0);
    n_checks++;
    if (obs_count !== 3'd3) $display("FAIL mid_pre_count: got %0d want 3", obs_count);
    else n_pass++;
    do_reset(16'h0100);
    #1;
    n_checks++;
    if ({o_valid, o_count, o_overflow} !== 5'b0)
      $display("FAIL mid_reset_status: got v=%b c=%0d o=%b want 0/0/0", o_valid, o_count,
               o_overflow);
    else n_pass++;
    @(negedge clk);
    repeat (4) begin
      tick(16'h0100, 1'b1);
      if (obs_valid === 1'b1) begin
        nvalid++;
        got = {obs_rel, obs_data};
      end
    end
    n_checks++;
    if (nvalid !== 1) $display("FAIL mid_valid_cycles: got %0d want 1", nvalid);
    else n_pass++;
    n_checks++;
    if (got !== 17'h00100) $display("FAIL mid_event: got %h want 00100", got);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic          rdy;
    do_reset(16'h0);
    for (int i = 0; i < 10000; i++) begin
      d = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) d = DW'($urandom);
      // Alternate between draining and starving phases to reach full/overflow.
      if (((i / 500) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
      else rdy = ($urandom_range(0, 3) == 0);
      tick(d, rdy);
      n_checks++;
      if ({obs_valid, obs_count, obs_ovf} !== {exp_valid, 3'(exp_count), exp_ovf})
        $display("FAIL rand_status cyc %0d: got v=%b c=%0d o=%b want v=%b c=%0d o=%b", i,
                 obs_valid, obs_count, obs_ovf, exp_valid, exp_count, exp_ovf);
      else n_pass++;
      if (popped) begin
        n_checks++;
        if ({obs_rel, obs_data} !== exp_head)
          $display("FAIL rand_head cyc %0d: got %b/%h want %h", i, obs_rel, obs_data, exp_head);
        else n_pass++;
      end
    end
  endtask

  initial begin
    m_last = '0;
    m_ovf  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_event();
    test_sequence();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/synth_event_queue.md
SYNTH_EVENT_QUEUE -- requirements
Module: synth_event_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of the note/control word from the device-tree input.
REQ-002 SHALL have parameter DEPTH, default 4, meaning event FIFO depth in entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_data  input  DATA_W  raw note/control word, sampled every cycle.
REQ-006 SHALL have port o_valid  output  1  head event available.
REQ-007 SHALL have port i_ready  input  1  consumer (bank manager) accepts head event.
REQ-008 SHALL have port o_data  output  DATA_W  head event word.
REQ-009 SHALL have port o_release  output  1  head event is a release, i.e. its word == 0.
REQ-010 SHALL have port o_count  output  $clog2(DEPTH)+1  entries held.
REQ-011 SHALL have port o_overflow  output  1  sticky flag: an event was dropped.

Function
REQ-012 SHALL hold register r_last (DATA_W) of the previous sampled i_data and detect change when i_data != r_last; X/Z values are not modelled.
REQ-013 SHALL update r_last <= i_data every cycle that is not in reset.
REQ-014 On change, SHALL push one entry {release = (i_data == 0), data = i_data} at the same clock edge; an unchanged input SHALL push nothing; one event per change, never repeated.
REQ-015 Latency: change sampled at edge t -> entry visible on o_data/o_release with o_valid=1 after edge t when the FIFO was empty; no combinational bypass from i_data to outputs.
REQ-016 Handshake: a pop SHALL occur at an edge where o_valid && i_ready; o_data/o_release SHALL stay stable while o_valid && !i_ready.
REQ-017 o_valid SHALL equal (o_count != 0); o_data/o_release are don't-care when o_valid=0 but SHALL NOT change except on push-into-empty or pop.
REQ-018 Push and pop at the same edge SHALL both occur, including when full; o_count unchanged.
REQ-019 Push when full without a simultaneous pop SHALL drop the new event, keep FIFO contents, and set o_overflow=1 at that edge.
REQ-020 o_overflow SHALL stay set until reset.
REQ-021 Pop when empty SHALL be impossible by REQ-016; i_ready with o_valid=0 has no effect.
REQ-022 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; o_count SHALL range 0..DEPTH.
REQ-023 Events SHALL leave in arrival order.

Reset
REQ-024 While i_reset=1 at an edge: r_last=0, pointers=0, o_count=0, o_valid=0, o_overflow=0, o_data=0, o_release=0; no push occurs that cycle.
REQ-025 Reset mid-operation SHALL discard all queued events.
REQ-026 After reset, i_data still nonzero SHALL produce exactly one event, because r_last=0.

Structure
REQ-027 A shared package synth_pkg SHALL hold the default DATA_W (16) and the event entry layout: release flag in MSB, data below.
REQ-028 The FIFO storage SHALL be one sub-module, synth_event_fifo, parametrised by width DATA_W+1 and DEPTH, with push/pop/full/empty/count; change detection and overflow logic SHALL stay in synth_event_queue.

Verification
REQ-029 Reset, then i_data=16'h0040 held 5 cycles with i_ready=1 -> exactly one event, o_data=0040, o_release=0, o_valid high 1 cycle.
REQ-030 i_ready=0; i_data sequence 0001,0002,0000 on consecutive cycles -> o_count=3; with i_ready=1, pops in order 0001,0002,0000; last pop has o_release=1.
REQ-031 DEPTH=4, i_ready=0, 5 distinct changes -> o_count=4, o_overflow=1, first 4 events retained, fifth lost.
REQ-032 Full FIFO with i_ready=1 and a new change at the same edge -> o_count stays 4, o_overflow stays 0, new event queued at the tail.
REQ-033 3 events queued, i_reset pulsed 1 cycle while i_data=0x0100 -> o_count=0, o_overflow=0, then exactly one event 0x0100.
REQ-034 Random i_data/i_ready for 10k cycles against a scoreboard -> order, count, no duplicates, overflow matches the model.
